rf_window_sched: RTL

- Round-robin scheduler that shares one timed RF activity window between NREQ wake-up requesters.
- Each requester raises a wake-up event on req_in.
- The block grants one requester at a time, holds the window active for WIN_CYCLES clocks, then enforces a guard gap before the next grant.
- Sits between the per-antenna RF detectors and the downstream capture/sync logic, which is gated by active and grant.

---
 rtl/rf_window_sched_pkg.sv | 21 ++
 rtl/rf_window_sched_rr_pick.sv | 40 ++++
 rtl/rf_window_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rf_window_sched_pkg.sv
// Shared types and constants for the RF window scheduler and related arbiters.
package rf_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GUARD  = 2'd2
  } state_e;

  localparam int DROP_W = 16;

  // One timer serves both the window and the guard phases, so it is sized
  // for the longer of the two (at least 1 bit).
  function automatic int timer_w(input int win_cycles, input int guard_cycles);
    int m;
    m = (win_cycles > guard_cycles) ? win_cycles : guard_cycles;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/rf_window_sched_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// the rr pointer, wrapping back to bit 0.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] rr,
  output logic          found,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Search the upper segment above rr first, then wrap to the lower segment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && pending[i] && (i > int'(rr))) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && pending[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

  // Expand the winning index into a one-hot vector.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = found && (IW'(i) == idx);
    end
  end

endmodule

// File: rtl/rf_window_sched.sv
// Round-robin scheduler sharing one timed RF activity window between NREQ
// wake-up requesters. Optional drop counter enabled by RF_WINDOW_DROP_CNT_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no window open; grants the next pending requester if en
// ST_ACTIVE | window open for WIN_CYCLES clocks, grant is one-hot owner
// ST_GUARD  | enforced idle gap of GUARD_CYCLES clocks after a window
module rf_window_sched
  import rf_sched_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int WIN_CYCLES   = 10000,
  parameter  int GUARD_CYCLES = 16,
  localparam int IDXW         = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_in,
  output logic              active,
  output logic [NREQ-1:0]   grant,
  output logic [IDXW-1:0]   grant_idx,
  output logic              win_done,
`ifdef RF_WINDOW_DROP_CNT_EN
  output logic [DROP_W-1:0] drop_cnt,
`endif
  output logic [NREQ-1:0]   pending
);

  localparam int TW = timer_w(WIN_CYCLES, GUARD_CYCLES);
  localparam logic [TW-1:0] WIN_LAST   = TW'(WIN_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LAST = TW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  state_e            state_q, state_d;
  logic              active_q, active_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   grant_idx_q, grant_idx_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic              win_done_q, win_done_d;
  logic [NREQ-1:0]   pending_q, pending_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NREQ-1:0]   req_q, req_d;

  logic [NREQ-1:0]   evt;
  logic [NREQ-1:0]   clr;
  logic              pick_found;
  logic [NREQ-1:0]   pick_onehot;
  logic [IDXW-1:0]   pick_idx;

  assign req_d = req_in;
  assign evt   = req_in & ~req_q;

  rr_pick #(.N(NREQ)) u_pick (
    .pending (pending_q),
    .rr      (rr_q),
    .found   (pick_found),
    .onehot  (pick_onehot),
    .idx     (pick_idx)
  );

  // Next-state logic for the window FSM and the pending latch.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_d        = rr_q;
    timer_d     = timer_q;
    win_done_d  = 1'b0;
    clr         = '0;

    case (state_q)
      ST_IDLE: begin
        if (en && pick_found) begin
          state_d     = ST_ACTIVE;
          active_d    = 1'b1;
          grant_d     = pick_onehot;
          grant_idx_d = pick_idx;
          rr_d        = pick_idx;
          timer_d     = '0;
          clr         = pick_onehot;
        end
      end
      ST_ACTIVE: begin
        if (timer_q == WIN_LAST) begin
          state_d    = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
          active_d   = 1'b0;
          grant_d    = '0;
          win_done_d = 1'b1;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_GUARD: begin
        if (timer_q == GUARD_LAST) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        active_d = 1'b0;
        grant_d  = '0;
        timer_d  = '0;
      end
    endcase

    // A fresh event beats a same-cycle grant so the re-request is not lost.
    pending_d = (pending_q & ~clr) | evt;
  end

  // Register all scheduler state; reset aborts any open window silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      active_q    <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= LAST_IDX;
      rr_q        <= LAST_IDX;
      win_done_q  <= 1'b0;
      pending_q   <= '0;
      timer_q     <= '0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_q        <= rr_d;
      win_done_q  <= win_done_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      req_q       <= req_d;
    end
  end

  assign active    = active_q;
  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign win_done  = win_done_q;
  assign pending   = pending_q;

`ifdef RF_WINDOW_DROP_CNT_EN
  localparam int SW = DROP_W + 1;

  logic [NREQ-1:0]   drops;
  logic [SW-1:0]     drop_sum;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  assign drops = evt & pending_q;

  // Saturating add of this cycle's drop popcount.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + SW'($countones(drops));
    drop_cnt_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
